fft_peak_scanner: RTL and testbench

FFT_PEAK_SCANNER -- requirements
Module: fft_peak_scanner

---
 rtl/fft_peak_scanner.sv | 179 +++++++++++++++++
 tb/tb_fft_peak_scanner.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_scanner.sv
// Scans one frame of FFT output RAM for the bin with the largest re^2+im^2.
// Reads stream out back-to-back; responses flow through a 3-stage square/sum/compare pipe.
module fft_peak_scanner #(
  parameter int BIN_LO  = 1,
  parameter int BIN_HI  = 255,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fft_done,
  output logic [8:0]         fft_address,
  output logic               fft_rd_en,
  input  logic               fft_read_valid,
  input  logic signed [17:0] data_in_real,
  input  logic signed [17:0] data_in_imag,
  output logic               busy,
  output logic               done,
  output logic [8:0]         peak_bin,
  output logic [35:0]        peak_mag,
  output logic               error,
  output logic               overrun
);

  localparam int NBINS = BIN_HI - BIN_LO + 1;
  localparam int CW    = $clog2(NBINS + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t         state_q;
  logic [8:0]     addr_q;
  logic           rd_en_q;
  logic [CW-1:0]  issued_q;
  logic [CW-1:0]  resp_cnt_q;
  logic [TW-1:0]  to_q;
  logic           s1_v_q;
  logic [34:0]    re2_q;
  logic [34:0]    im2_q;
  logic [8:0]     s1_bin_q;
  logic           s2_v_q;
  logic [35:0]    sum_q;
  logic [8:0]     s2_bin_q;
  logic [35:0]    max_q;
  logic [8:0]     best_q;
  logic           busy_q;
  logic           done_q;
  logic           error_q;
  logic           overrun_q;
  logic [8:0]     peak_bin_q;
  logic [35:0]    peak_mag_q;

  // 35-bit context keeps -131072^2 = 2^34 exact as an unsigned pattern.
  logic signed [34:0] re_sq_d;
  logic signed [34:0] im_sq_d;
  logic [35:0]        sum_d;
  logic [8:0]         tag_d;
  logic               active_d;
  logic               outstanding_d;
  logic               accept_d;
  logic               timeout_d;

  assign re_sq_d       = data_in_real * data_in_real;
  assign im_sq_d       = data_in_imag * data_in_imag;
  assign sum_d         = {1'b0, re2_q} + {1'b0, im2_q};
  assign tag_d         = 9'(BIN_LO) + 9'(resp_cnt_q);
  assign active_d      = (state_q == ISSUE) || (state_q == DRAIN);
  assign outstanding_d = (issued_q != resp_cnt_q);
  assign accept_d      = active_d && outstanding_d && fft_read_valid;
  assign timeout_d     = active_d && outstanding_d && !fft_read_valid && (to_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rd_en_q    <= 1'b0;
      issued_q   <= '0;
      resp_cnt_q <= '0;
      to_q       <= '0;
      s1_v_q     <= 1'b0;
      re2_q      <= '0;
      im2_q      <= '0;
      s1_bin_q   <= '0;
      s2_v_q     <= 1'b0;
      sum_q      <= '0;
      s2_bin_q   <= '0;
      max_q      <= '0;
      best_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      overrun_q  <= 1'b0;
      peak_bin_q <= '0;
      peak_mag_q <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;

      s1_v_q <= accept_d;
      if (accept_d) begin
        re2_q      <= re_sq_d;
        im2_q      <= im_sq_d;
        s1_bin_q   <= tag_d;
        resp_cnt_q <= resp_cnt_q + CW'(1);
      end
      s2_v_q   <= s1_v_q;
      sum_q    <= sum_d;
      s2_bin_q <= s1_bin_q;
      // Strict compare so equal magnitudes keep the earlier (lower) bin.
      if (s2_v_q && (sum_q > max_q)) begin
        max_q  <= sum_q;
        best_q <= s2_bin_q;
      end

      if (rd_en_q)
        issued_q <= issued_q + CW'(1);
      if (fft_done && (state_q != IDLE))
        overrun_q <= 1'b1;
      if (active_d)
        to_q <= (accept_d || !outstanding_d) ? '0 : to_q + TW'(1);

      case (state_q)
        IDLE: begin
          if (fft_done) begin
            state_q    <= ISSUE;
            busy_q     <= 1'b1;
            rd_en_q    <= 1'b1;
            addr_q     <= 9'(BIN_LO);
            max_q      <= '0;
            best_q     <= 9'(BIN_LO);
            resp_cnt_q <= '0;
            issued_q   <= '0;
            to_q       <= '0;
            s1_v_q     <= 1'b0;
            s2_v_q     <= 1'b0;
          end
        end
        ISSUE: begin
          if (addr_q == 9'(BIN_HI)) begin
            rd_en_q <= 1'b0;
            state_q <= DRAIN;
          end else begin
            addr_q <= addr_q + 9'd1;
          end
        end
        DRAIN: begin
          if ((resp_cnt_q == CW'(NBINS)) && !s1_v_q && !s2_v_q)
            state_q <= FINISH;
        end
        FINISH: begin
          done_q     <= 1'b1;
          peak_bin_q <= best_q;
          peak_mag_q <= max_q;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Abort overrides the normal ISSUE/DRAIN progress.
      if (timeout_d) begin
        error_q <= 1'b1;
        state_q <= IDLE;
        busy_q  <= 1'b0;
        rd_en_q <= 1'b0;
        to_q    <= '0;
      end
    end
  end

  assign fft_address = addr_q;
  assign fft_rd_en   = rd_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign overrun     = overrun_q;
  assign peak_bin    = peak_bin_q;
  assign peak_mag    = peak_mag_q;

endmodule

// File: tb/tb_fft_peak_scanner.sv
// Directed bench for fft_peak_scanner with a latency-2 RAM model.
module tb_fft_peak_scanner;
  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               fft_done = 1'b0;
  logic [8:0]         fft_address;
  logic               fft_rd_en;
  logic               fft_read_valid;
  logic signed [17:0] data_in_real;
  logic signed [17:0] data_in_imag;
  logic               busy;
  logic               done;
  logic [8:0]         peak_bin;
  logic [35:0]        peak_mag;
  logic               error;
  logic               overrun;

  always #5 clk = ~clk;

  fft_peak_scanner dut (
    .clk(clk), .reset(reset), .fft_done(fft_done),
    .fft_address(fft_address), .fft_rd_en(fft_rd_en),
    .fft_read_valid(fft_read_valid),
    .data_in_real(data_in_real), .data_in_imag(data_in_imag),
    .busy(busy), .done(done), .peak_bin(peak_bin), .peak_mag(peak_mag),
    .error(error), .overrun(overrun)
  );

  // RAM model: two-cycle read latency, optional cut-off after ram_limit responses.
  int         mode = 0;
  int         ram_limit = 1000000;
  int         ram_base = 0;
  int         served_q = 0;
  logic       stray = 1'b0;
  logic       p1_q = 1'b0;
  logic       p2_q = 1'b0;
  logic [8:0] a1_q = '0;
  logic [8:0] a2_q = '0;

  always @(posedge clk) begin
    p1_q <= fft_rd_en;
    a1_q <= fft_address;
    a2_q <= a1_q;
    p2_q <= p1_q && ((served_q - ram_base) < ram_limit);
    if (p1_q && ((served_q - ram_base) < ram_limit))
      served_q <= served_q + 1;
  end

  assign fft_read_valid = p2_q || stray;

  always_comb begin
    data_in_real = 18'sd0;
    data_in_imag = 18'sd0;
    case (mode)
      0: if (a2_q == 9'd100) begin data_in_real = 18'sd300; data_in_imag = -18'sd400; end
         else begin data_in_real = 18'sd1; data_in_imag = 18'sd1; end
      1: if (a2_q == 9'd40 || a2_q == 9'd90) begin data_in_real = -18'sd131072; data_in_imag = 18'sd0; end
         else begin data_in_real = 18'sd1; data_in_imag = 18'sd1; end
      3: if (a2_q == 9'd7 || a2_q == 9'd200) begin data_in_real = -18'sd131072; data_in_imag = -18'sd131072; end
         else begin data_in_real = 18'sd1; data_in_imag = 18'sd1; end
      default: begin data_in_real = 18'sd0; data_in_imag = 18'sd0; end
    endcase
  end

  // Edge monitor: cycle count, read sequence, responses, done/error pulses.
  int         cyc = 0;
  int         rd_cnt = 0;
  int         last_vcyc = 0;
  int         addr_err = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  logic       prev_rd = 1'b0;
  logic [8:0] prev_addr = '0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (fft_read_valid) last_vcyc = cyc;
    if (fft_rd_en) begin
      rd_cnt = rd_cnt + 1;
      if (fft_address != (prev_rd ? prev_addr + 9'd1 : 9'd1)) addr_err = addr_err + 1;
    end
    prev_rd   = fft_rd_en;
    prev_addr = fft_address;
    if (done)  done_cnt = done_cnt + 1;
    if (error) err_cnt = err_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output logic found, output int at_cyc);
    found = 1'b0;
    at_cyc = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (done) begin found = 1'b1; at_cyc = cyc; break; end
    end
  endtask

  task automatic wait_error(input int maxc, output logic found, output int at_cyc);
    found = 1'b0;
    at_cyc = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (error) begin found = 1'b1; at_cyc = cyc; break; end
    end
  endtask

  logic found;
  int   at_cyc;
  int   rd_base;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_overrun", overrun, 0);
    check("rst_rd_en", fft_rd_en, 0);
    check("rst_addr", fft_address, 0);
    check("rst_peak_bin", peak_bin, 0);
    check("rst_peak_mag", peak_mag, 0);
    reset = 1'b0;
    @(negedge clk);

    // Scan 1: single strong bin at 100.
    mode = 0;
    rd_base = rd_cnt;
    pulse_start();
    check("s1_busy_rise", busy, 1);
    check("s1_first_addr", fft_address, 1);
    check("s1_first_rd", fft_rd_en, 1);
    wait_done(700, found, at_cyc);
    check("s1_done_seen", found, 1);
    check("s1_peak_bin", peak_bin, 100);
    check("s1_peak_mag", peak_mag, 250000);
    check("s1_done_latency", at_cyc - last_vcyc, 4);
    check("s1_reads", rd_cnt - rd_base, 255);
    check("s1_addr_seq", addr_err, 0);
    check("s1_busy_fall", busy, 0);

    // Scan 2 starts the cycle right after done; tie between bins 40 and 90.
    mode = 1;
    rd_base = rd_cnt;
    pulse_start();
    check("s2_busy", busy, 1);
    check("s2_no_overrun", overrun, 0);
    wait_done(700, found, at_cyc);
    check("s2_done_seen", found, 1);
    check("s2_peak_bin", peak_bin, 40);
    check("s2_peak_mag", peak_mag, 64'd17179869184);
    check("s2_reads", rd_cnt - rd_base, 255);
    repeat (2) @(negedge clk);
    check("s2_done_width", done, 0);
    check("s2_done_count", done_cnt, 2);

    // Scan 3: RAM goes silent after 10 responses.
    mode = 0;
    ram_base = served_q;
    ram_limit = 10;
    pulse_start();
    wait_error(500, found, at_cyc);
    check("to_error_seen", found, 1);
    check("to_error_delay", at_cyc - last_vcyc, 64);
    check("to_busy_fall", busy, 0);
    check("to_rd_off", fft_rd_en, 0);
    check("to_peak_bin_kept", peak_bin, 40);
    check("to_peak_mag_kept", peak_mag, 64'd17179869184);
    @(negedge clk);
    check("to_error_width", error, 0);
    repeat (10) @(negedge clk);
    check("to_no_done", done_cnt, 2);
    check("to_error_count", err_cnt, 1);
    ram_limit = 1000000;

    // Scan 4: all-zero frame plus a second fft_done while busy.
    mode = 2;
    pulse_start();
    repeat (5) @(negedge clk);
    pulse_start();
    check("ov_set", overrun, 1);
    wait_done(700, found, at_cyc);
    check("z_done_seen", found, 1);
    check("z_peak_bin", peak_bin, 1);
    check("z_peak_mag", peak_mag, 0);
    check("ov_sticky", overrun, 1);
    repeat (2) @(negedge clk);
    check("z_done_count", done_cnt, 3);

    // Scan 5: reset mid-scan, stray valids afterwards, then a clean rescan.
    mode = 0;
    rd_base = rd_cnt;
    pulse_start();
    for (int i = 0; i < 400 && (rd_cnt - rd_base) < 120; i++) @(negedge clk);
    check("mr_reached_120", (rd_cnt - rd_base) >= 120, 1);
    reset = 1'b1;
    #1;
    check("mr_busy", busy, 0);
    check("mr_rd_en", fft_rd_en, 0);
    check("mr_addr", fft_address, 0);
    check("mr_peak_bin", peak_bin, 0);
    check("mr_peak_mag", peak_mag, 0);
    check("mr_overrun", overrun, 0);
    @(negedge clk);
    fft_done = 1'b1;
    @(negedge clk);
    fft_done = 1'b0;
    reset = 1'b0;
    stray = 1'b1;
    repeat (3) @(negedge clk);
    stray = 1'b0;
    repeat (5) @(negedge clk);
    check("mr_no_start", busy, 0);
    check("mr_no_read", fft_rd_en, 0);
    check("mr_no_done", done_cnt, 3);
    check("mr_no_error", err_cnt, 1);

    mode = 3;
    rd_base = rd_cnt;
    pulse_start();
    wait_done(700, found, at_cyc);
    check("rs_done_seen", found, 1);
    check("rs_peak_bin", peak_bin, 7);
    check("rs_peak_mag", peak_mag, 64'd34359738368);
    check("rs_reads", rd_cnt - rd_base, 255);
    check("rs_addr_seq", addr_err, 0);
    repeat (2) @(negedge clk);
    check("rs_done_count", done_cnt, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
